// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
//   issues one request at a time to a variable-latency instruction memory and
//   presents the returned instruction (with its PC+4) until IF/ID consumes it.
//   A NOP bubble (all zeros, ins_valid=0) is driven whenever nothing is ready.
//   Branch/jump redirects from ID replace the PC and squash any fetch that is
//   already in flight.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   PC_write                     1 = IF/ID consumes the presented instruction
//   branch_taken, branch_target  branch redirect (priority over jump)
//   jump, jump_target            jump redirect
//   imem_req, imem_addr          request handshake / address (= pc)
//   imem_ready                   memory accepts request on imem_req && imem_ready
//   imem_rvalid, imem_rdata      one response per accepted request
//   Ins_out, PC_plus4_out        instruction and its PC+4 (zero when not valid)
//   ins_valid                    Ins_out/PC_plus4_out hold a real instruction
//   PC_out                       current pc
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Ins_out,
  output logic [31:0] PC_plus4_out,
  output logic        ins_valid,
  output logic [31:0] PC_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  logic [31:0] ins_q, ins_nxt;
  logic [31:0] pcp4_q, pcp4_nxt;
  logic        vld_q, vld_nxt;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;

  assign redirect    = branch_taken | jump;
  // Targets are forced word-aligned; branch wins when both redirects fire.
  assign redirect_pc = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
  assign pc_plus4    = pc + 32'd4;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      drop   <= 1'b0;
      ins_q  <= 32'b0;
      pcp4_q <= 32'b0;
      vld_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      drop   <= drop_nxt;
      ins_q  <= ins_nxt;
      pcp4_q <= pcp4_nxt;
      vld_q  <= vld_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    ins_nxt   = ins_q;
    pcp4_nxt  = pcp4_q;
    vld_nxt   = vld_q;

    if (redirect) begin
      pc_nxt   = redirect_pc;
      ins_nxt  = 32'b0;
      pcp4_nxt = 32'b0;
      vld_nxt  = 1'b0;
    end

    case (state)
      S_REQ: begin
        if (imem_ready) begin
          state_nxt = S_WAIT;
          // The old-address request was accepted this edge; its data is stale.
          if (redirect) drop_nxt = 1'b1;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          if (imem_rvalid) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            drop_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            ins_nxt   = imem_rdata;
            pcp4_nxt  = pc_plus4;
            vld_nxt   = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          state_nxt = S_REQ;
        end else if (PC_write) begin
          pc_nxt    = pc_plus4;
          ins_nxt   = 32'b0;
          pcp4_nxt  = 32'b0;
          vld_nxt   = 1'b0;
          state_nxt = S_REQ;
        end
      end

      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // Request is suppressed while reset is held so the first request appears
  // in the cycle after reset deasserts.
  assign imem_req     = (state == S_REQ) && !reset;
  assign imem_addr    = pc;
  assign Ins_out      = ins_q;
  assign PC_plus4_out = pcp4_q;
  assign ins_valid    = vld_q;
  assign PC_out       = pc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to a variable-latency instruction memory.
- Presents each fetched instruction and its PC+4 to IF/ID; drives a NOP bubble when no instruction is ready.
- Obeys the hazard unit's PC_write stall and redirects on branch/jump resolved in ID, squashing stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- reset  in  1  asynchronous, active-high reset.
- PC_write  in  1  1 = IF/ID may consume the presented instruction (same signal as IFID_write); 0 = stall.
- branch_taken  in  1  redirect to branch_target this cycle.
- branch_target  in  32  branch destination.
- jump  in  1  redirect to jump_target this cycle.
- jump_target  in  32  jump destination.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (= pc).
- imem_ready  in  1  memory accepts request when imem_req && imem_ready at posedge.
- imem_rvalid  in  1  read data valid, one cycle per accepted request, ≥1 cycle after acceptance.
- imem_rdata  in  32  instruction word.
- Ins_out  out  32  instruction to IF/ID; 32'b0 when ins_valid=0.
- PC_plus4_out  out  32  fetched PC+4 to IF/ID; 32'b0 when ins_valid=0.
- ins_valid  out  1  Ins_out/PC_plus4_out hold a real instruction.
- PC_out  out  32  current pc (debug/visibility).

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=REQ, drop=0, ins_valid=0, Ins_out=0, PC_plus4_out=0. imem_req becomes 1 in the first cycle after reset deasserts.
- States:
  - REQ: imem_req=1, imem_addr=pc.
  - WAIT: one request outstanding; imem_req=0.
  - HOLD: instruction presented; ins_valid=1; imem_req=0.
- Non-redirect transitions:
  - REQ & imem_ready: go to WAIT.
  - REQ & !imem_ready: stay in REQ.
  - WAIT & imem_rvalid & !drop: Ins_out<=imem_rdata, PC_plus4_out<=pc+4, ins_valid<=1; go to HOLD.
  - WAIT & imem_rvalid & drop: discard data, drop<=0; go to REQ.
  - HOLD & PC_write: instruction consumed; pc<=pc+4, ins_valid<=0, outputs<=0; go to REQ.
  - HOLD & !PC_write: hold all outputs and pc unchanged.
- Redirect = branch_taken | jump. branch_taken has priority over jump.
  - new pc = selected target with bits[1:0] forced to 00.
  - Redirect overrides PC_write in the same cycle.
  - Always on redirect: pc<=target, ins_valid<=0, Ins_out<=0, PC_plus4_out<=0.
  - REQ & !imem_ready: stay in REQ; imem_addr shows the new pc next cycle.
  - REQ & imem_ready: old-address request was accepted; go to WAIT with drop<=1.
  - WAIT & !imem_rvalid: drop<=1, stay in WAIT.
  - WAIT & imem_rvalid: response discarded, drop<=0; go to REQ.
  - HOLD: go to REQ.
- Arithmetic: pc+4 is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0.
- Latency/throughput: minimum 3 cycles per instruction (REQ, WAIT, HOLD) with imem_ready=1 and rvalid one cycle after acceptance. At most one outstanding request at any time.
- Memory data: imem_rvalid outside WAIT is a protocol violation; it is ignored and no state changes.
- Reset mid-operation: an outstanding request is abandoned; the memory is also reset by the same reset.

Test Plan:
- Reset with RESET_PC=32'h100, memory ready=1, 1-cycle latency returning 32'hAAAA_0001 at 0x100 → imem_addr=0x100; Ins_out=32'hAAAA_0001, PC_plus4_out=0x104, ins_valid=1 in HOLD; next request addr=0x104.
- Stall: PC_write=0 for 4 cycles while in HOLD → Ins_out/PC_plus4_out/pc unchanged and imem_req=0; PC_write=1 → pc=0x108, ins_valid=0 next cycle.
- Redirect during WAIT: branch_taken=1, branch_target=0x200 while the 0x104 fetch is outstanding, rvalid arrives 2 cycles later → data discarded, ins_valid stays 0, next imem_addr=0x200.
- Simultaneous branch_taken (target 0x300) and jump (target 0x400) in HOLD with PC_write=1 → pc=0x300, ins_valid=0, next request addr 0x300.
- Misaligned/wrap: jump_target=32'h0000_0503 → pc=0x500. Fetch at 32'hFFFF_FFFC consumed → PC_plus4_out=0, next addr 0.
- Async reset asserted mid-WAIT, between clock edges → outputs clear immediately, pc=RESET_PC, state REQ after deassertion, late rvalid ignored.
